// File: rtl/pc_branch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_branch_unit_pkg : shared defaults and next-PC select encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package pc_branch_unit_pkg;

    localparam int          C_PC_W_DEF      = 16;
    localparam int          C_RAS_DEPTH_DEF = 4;
    localparam logic [15:0] C_RESET_PC_DEF  = 16'h0000;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } next_sel_e;

    // First match wins: ret, call, jump, taken branch, then sequential.
    function automatic next_sel_e sel_next(input logic ret, input logic call,
                                           input logic jump, input logic br_taken);
        if (ret)           return SEL_RET;
        else if (call)     return SEL_CALL;
        else if (jump)     return SEL_JMP;
        else if (br_taken) return SEL_BR;
        else               return SEL_SEQ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_branch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_branch_unit_if : control-flow inputs and PC/status outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_branch_unit_if #(
    parameter int PC_W = pc_branch_unit_pkg::C_PC_W_DEF
);
    logic            stall;
    logic            instr_valid;
    logic            is_branch;
    logic            is_jump;
    logic            is_call;
    logic            is_ret;
    logic            cmp_out;
    logic [PC_W-1:0] br_offset;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc;
    logic            redirect;
    logic [15:0]     taken_count;
    logic            ras_overflow;
    logic            ras_underflow;

    modport master (
        output stall, instr_valid, is_branch, is_jump, is_call, is_ret,
               cmp_out, br_offset, jump_target,
        input  pc, redirect, taken_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, instr_valid, is_branch, is_jump, is_call, is_ret,
               cmp_out, br_offset, jump_target,
        output pc, redirect, taken_count, ras_overflow, ras_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_branch_unit_ras_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_branch_unit_ras_stack : circular return-address stack, oldest overwritten
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_branch_unit_ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [W-1:0] din,
    output logic [W-1:0]      dout,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (push) begin
            // Full push wraps onto the oldest slot; count stays at DEPTH.
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (r_count != CNT_W'(DEPTH))
                r_count <= r_count + CNT_W'(1);
        end else if (pop) begin
            r_wr_ptr <= r_wr_ptr - PTR_W'(1);
            r_count  <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_wr_ptr - PTR_W'(1)];
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_branch_unit : next-PC selection, redirect, taken counter and RAS flags
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int              PC_W      = C_PC_W_DEF,
    parameter int              RAS_DEPTH = C_RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(C_RESET_PC_DEF)
) (
    input wire logic          clk,
    input wire logic          rst,
    pc_branch_unit_if.slave   bus
);
    logic [PC_W-1:0] r_pc;
    logic            r_redirect;
    logic [15:0]     r_taken_count;
    logic            r_ras_overflow;
    logic            r_ras_underflow;

    logic            w_adv;
    next_sel_e       w_sel;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_next_pc;
    logic            w_taken;
    logic            w_push;
    logic            w_pop;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    assign w_adv    = !bus.stall && bus.instr_valid;
    assign w_sel    = sel_next(bus.is_ret, bus.is_call, bus.is_jump,
                               bus.is_branch && bus.cmp_out);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_taken  = (w_sel != SEL_SEQ);
    // A simultaneous call is swallowed by the ret, so push and pop never coincide.
    assign w_push   = w_adv && (w_sel == SEL_CALL);
    assign w_pop    = w_adv && (w_sel == SEL_RET) && !w_ras_empty;

    always_comb begin
        w_next_pc = w_pc_inc;
        case (w_sel)
            SEL_RET:  w_next_pc = w_ras_empty ? RESET_PC : w_ras_top;
            SEL_CALL: w_next_pc = bus.jump_target;
            SEL_JMP:  w_next_pc = bus.jump_target;
            SEL_BR:   w_next_pc = w_pc_inc + bus.br_offset;
            default:  w_next_pc = w_pc_inc;
        endcase
    end

    pc_branch_unit_ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_ras_top),
        .empty (w_ras_empty),
        .full  (w_ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_redirect      <= 1'b0;
            r_taken_count   <= '0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else if (w_adv) begin
            r_pc       <= w_next_pc;
            r_redirect <= w_taken;
            if (w_taken && (r_taken_count != 16'hFFFF))
                r_taken_count <= r_taken_count + 16'd1;
            if (w_push && w_ras_full)
                r_ras_overflow <= 1'b1;
            if ((w_sel == SEL_RET) && w_ras_empty)
                r_ras_underflow <= 1'b1;
        end else begin
            r_redirect <= 1'b0;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.redirect      = r_redirect;
    assign bus.taken_count   = r_taken_count;
    assign bus.ras_overflow  = r_ras_overflow;
    assign bus.ras_underflow = r_ras_underflow;
endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_branch_unit : directed vector table, corner sequences, random vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.PC_W(16)) bus ();

    pc_branch_unit #(
        .PC_W      (16),
        .RAS_DEPTH (4),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: a bounded list of return addresses, newest at the back.
    logic [15:0] m_pc;
    logic        m_redir;
    int          m_cnt;
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_ras[$];

    typedef struct {
        logic        stall, valid, br, jmp, call, ret, cmp;
        logic [15:0] off, tgt;
        logic [15:0] exp_pc;
        logic        exp_redir;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic st, input logic v, input logic br,
                                input logic j, input logic c, input logic r,
                                input logic cmp, input logic [15:0] off,
                                input logic [15:0] tgt, input logic [15:0] epc,
                                input logic ered);
        vec_t t;
        t.stall = st; t.valid = v; t.br = br; t.jmp = j; t.call = c; t.ret = r;
        t.cmp = cmp; t.off = off; t.tgt = tgt; t.exp_pc = epc; t.exp_redir = ered;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic br, input logic j,
                         input logic c, input logic r, input logic cmp,
                         input logic [15:0] off, input logic [15:0] tgt);
        bus.stall = st; bus.instr_valid = v; bus.is_branch = br; bus.is_jump = j;
        bus.is_call = c; bus.is_ret = r; bus.cmp_out = cmp;
        bus.br_offset = off; bus.jump_target = tgt;
    endtask

    task automatic model_step();
        logic taken;
        taken = 1'b0;
        if (rst) begin
            m_pc = 16'h0000; m_redir = 1'b0; m_cnt = 0;
            m_ovf = 1'b0; m_unf = 1'b0; m_ras.delete();
        end else if (!bus.stall && bus.instr_valid) begin
            taken = 1'b1;
            if (bus.is_ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = 16'h0000; m_unf = 1'b1; end
            end else if (bus.is_call) begin
                m_ras.push_back(m_pc + 16'd1);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = bus.jump_target;
            end else if (bus.is_jump) begin
                m_pc = bus.jump_target;
            end else if (bus.is_branch && bus.cmp_out) begin
                m_pc = m_pc + 16'd1 + bus.br_offset;
            end else begin
                m_pc = m_pc + 16'd1;
                taken = 1'b0;
            end
            m_redir = taken;
            if (taken && m_cnt < 65535) m_cnt++;
        end else begin
            m_redir = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".pc"},       {16'h0, bus.pc},          {16'h0, m_pc});
        chk({tag, ".redirect"}, {31'h0, bus.redirect},    {31'h0, m_redir});
        chk({tag, ".taken"},    {16'h0, bus.taken_count}, m_cnt);
        chk({tag, ".ovf"},      {31'h0, bus.ras_overflow},  {31'h0, m_ovf});
        chk({tag, ".unf"},      {31'h0, bus.ras_underflow}, {31'h0, m_unf});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},       {16'h0, bus.pc},            32'h0);
        chk({tag, ".redirect"}, {31'h0, bus.redirect},      32'h0);
        chk({tag, ".taken"},    {16'h0, bus.taken_count},   32'h0);
        chk({tag, ".ovf"},      {31'h0, bus.ras_overflow},  32'h0);
        chk({tag, ".unf"},      {31'h0, bus.ras_underflow}, 32'h0);
    endtask

    logic [15:0] exp_rets[4];

    initial begin
        // Directed table: reset walk, branch both ways, call/ret, stall/invalid hold.
        vecs[0]  = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0001, 0);
        vecs[1]  = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0002, 0);
        vecs[2]  = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0003, 0);
        vecs[3]  = mk(0,1,0,1,0,0,0, 16'h0000, 16'h0010, 16'h0010, 1);
        vecs[4]  = mk(0,1,1,0,0,0,1, 16'hFFFC, 16'h0000, 16'h000D, 1);
        vecs[5]  = mk(0,1,0,1,0,0,0, 16'h0000, 16'h0010, 16'h0010, 1);
        vecs[6]  = mk(0,1,1,0,0,0,0, 16'hFFFC, 16'h0000, 16'h0011, 0);
        vecs[7]  = mk(0,1,0,1,0,0,0, 16'h0000, 16'h0020, 16'h0020, 1);
        vecs[8]  = mk(0,1,0,0,1,0,0, 16'h0000, 16'h0100, 16'h0100, 1);
        vecs[9]  = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0101, 0);
        vecs[10] = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0102, 0);
        vecs[11] = mk(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 16'h0103, 0);
        vecs[12] = mk(0,1,0,0,0,1,0, 16'h0000, 16'h0000, 16'h0021, 1);
        vecs[13] = mk(1,1,0,1,0,0,0, 16'h0000, 16'h0500, 16'h0021, 0);
        vecs[14] = mk(0,0,0,1,0,0,0, 16'h0000, 16'h0500, 16'h0021, 0);

        exp_rets[0] = 16'h0501; exp_rets[1] = 16'h0401;
        exp_rets[2] = 16'h0301; exp_rets[3] = 16'h0201;

        drive(0,0,0,0,0,0,0, 16'h0, 16'h0);
        rst = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].valid, vecs[i].br, vecs[i].jmp,
                  vecs[i].call, vecs[i].ret, vecs[i].cmp, vecs[i].off, vecs[i].tgt);
            tick();
            chk($sformatf("vec%0d.pc", i), {16'h0, bus.pc}, {16'h0, vecs[i].exp_pc});
            chk($sformatf("vec%0d.redir", i), {31'h0, bus.redirect}, {31'h0, vecs[i].exp_redir});
        end
        chk("table.taken", {16'h0, bus.taken_count}, 32'd6);
        cmp_model("table");

        // RAS depth limits: five nested calls, then five returns.
        drive(0,1,0,1,0,0,0, 16'h0, 16'h0021); tick();
        for (int k = 0; k < 5; k++) begin
            drive(0,1,0,0,1,0,0, 16'h0, 16'h0200 + 16'(k) * 16'h0100);
            tick();
            if (k == 3) chk("ras.ovf_after4", {31'h0, bus.ras_overflow}, 32'h0);
        end
        chk("ras.ovf_after5", {31'h0, bus.ras_overflow}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            drive(0,1,0,0,0,1,0, 16'h0, 16'h0);
            tick();
            chk($sformatf("ras.ret%0d", k), {16'h0, bus.pc}, {16'h0, exp_rets[k]});
        end
        chk("ras.unf_before", {31'h0, bus.ras_underflow}, 32'h0);
        drive(0,1,0,0,0,1,0, 16'h0, 16'h0); tick();
        chk("ras.ret_empty_pc", {16'h0, bus.pc}, 32'h0);
        chk("ras.unf_after", {31'h0, bus.ras_underflow}, 32'h1);
        cmp_model("ras");

        // Call and ret together: ret wins, no push.
        drive(0,1,0,1,0,0,0, 16'h0, 16'h0041); tick();
        drive(0,1,0,0,1,0,0, 16'h0, 16'h0900); tick();
        drive(0,1,0,0,1,1,0, 16'h0, 16'h0777); tick();
        chk("callret.pc", {16'h0, bus.pc}, 32'h0042);
        drive(0,1,0,0,0,1,0, 16'h0, 16'h0); tick();
        chk("callret.empty_pc", {16'h0, bus.pc}, 32'h0);
        cmp_model("callret");

        // PC wrap on sequential advance.
        drive(0,1,0,1,0,0,0, 16'h0, 16'hFFFF); tick();
        drive(0,1,0,0,0,0,0, 16'h0, 16'h0); tick();
        chk("wrap.pc", {16'h0, bus.pc}, 32'h0);

        // Counter saturation.
        drive(0,1,0,1,0,0,0, 16'h0, 16'h1234);
        while (m_cnt < 16'hFFFE) tick();
        chk("sat.fffe", {16'h0, bus.taken_count}, 32'hFFFE);
        for (int k = 0; k < 3; k++) tick();
        chk("sat.ffff", {16'h0, bus.taken_count}, 32'hFFFF);
        cmp_model("sat");

        // Reset wins over stall.
        drive(1,1,0,1,0,0,0, 16'h0, 16'h0333);
        rst = 1'b1;
        tick();
        chk_reset_state("rst_stall");
        rst = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0,7) == 0, $urandom_range(0,9) != 0,
                  $urandom_range(0,3) == 0, $urandom_range(0,5) == 0,
                  $urandom_range(0,4) == 0, $urandom_range(0,4) == 0,
                  1'($urandom), 16'($urandom), 16'($urandom));
            tick();
            cmp_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
